// File: rtl/offnariscv_pkg.sv
// rtl/offnariscv_pkg.sv - shared types for the execute/writeback path
package offnariscv_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic alu_cmd_vld;
      logic bru_cmd_vld;
      logic sys_cmd_vld;
   } id_data_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic            rd_we;
      id_data_t        id_data;
   } exwb_tdata_t;

   typedef struct packed {
      logic [XLEN-1:0] wdata;
   } alu_result_t;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] link;
   } bru_result_t;

   typedef struct packed {
      logic [XLEN-1:0] wdata;
      logic            trap;
      logic            redirect;
      logic [XLEN-1:0] pc;
   } sys_result_t;

   typedef struct packed {
      logic [4:0]      rd;
      logic            wen;
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] pc;
   } wbrf_tdata_t;

   typedef enum logic [1:0] {IDLE, WAIT, OUT} ex_col_state_e;

   localparam int EXWB_W = $bits(exwb_tdata_t);
   localparam int ALU_W  = $bits(alu_result_t);
   localparam int BRU_W  = $bits(bru_result_t);
   localparam int SYS_W  = $bits(sys_result_t);
   localparam int WBRF_W = $bits(wbrf_tdata_t);

endpackage

// File: rtl/ex_collector_hold.sv
// rtl/ex_collector_hold.sv - one execution unit's result capture register with got flag
module ex_result_hold #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_need,
   input  logic i_clear,
   input  T     i_tdata,
   input  logic i_tvalid,
   output logic o_tready,
   output logic o_done,
   output T     o_data
);

   T     r_data;
   logic r_got;
   logic w_hs;

   assign o_tready = i_en && i_need && !r_got;
   assign w_hs     = o_tready && i_tvalid;
   // Done counts a beat accepted this cycle so the merge can be registered on the same edge.
   assign o_done   = !i_need || r_got || w_hs;
   assign o_data   = w_hs ? i_tdata : r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_got  <= 1'b0;
         r_data <= '0;
      end else if (i_clear) begin
         r_got  <= 1'b0;
      end else if (w_hs) begin
         r_got  <= 1'b1;
         r_data <= i_tdata;
      end
   end

endmodule

// File: rtl/ex_collector.sv
// rtl/ex_collector.sv - merges dispatcher header and unit results into one writeback beat
module ex_collector
   import offnariscv_pkg::*;
#(
   parameter bit BYPASS      = 1'b1,
   parameter int WDOG_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [EXWB_W-1:0] i_exwb_tdata,
   input  logic              i_exwb_tvalid,
   output logic              o_exwb_tready,
   input  logic [ALU_W-1:0]  i_alu_tdata,
   input  logic              i_alu_tvalid,
   output logic              o_alu_tready,
   input  logic [BRU_W-1:0]  i_bru_tdata,
   input  logic              i_bru_tvalid,
   output logic              o_bru_tready,
   input  logic [SYS_W-1:0]  i_sys_tdata,
   input  logic              i_sys_tvalid,
   output logic              o_sys_tready,
   output logic [WBRF_W-1:0] o_wbrf_tdata,
   output logic              o_wbrf_tvalid,
   input  logic              i_wbrf_tready,
   output logic              redirect_vld,
   output logic [XLEN-1:0]   redirect_pc,
   input  logic              invalidate,
   output logic              wdog_err
);

   localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYCLES);

   ex_col_state_e r_state, w_state_nxt;
   exwb_tdata_t   r_hdr, w_hdr_in, w_hdr;
   wbrf_tdata_t   r_wb, w_wb_nxt;
   alu_result_t   w_alu;
   bru_result_t   w_bru;
   sys_result_t   w_sys;
   logic          r_live, r_take, r_redirect_vld, r_wdog_err;
   logic [XLEN-1:0] r_take_pc, r_redirect_pc, w_redir_pc;
   logic [31:0]   r_wdog_cnt;
   logic          w_need_alu, w_need_bru, w_need_sys;
   logic          w_done_alu, w_done_bru, w_done_sys;
   logic          w_exwb_hs, w_wbrf_hs, w_bypass_ok, w_unit_en, w_clear, w_load_out;
   logic          w_trap, w_sys_redir, w_bru_redir, w_redir_take;

   assign w_hdr_in   = i_exwb_tdata;
   assign w_hdr      = (r_state == IDLE) ? w_hdr_in : r_hdr;
   assign w_need_alu = w_hdr.id_data.alu_cmd_vld;
   assign w_need_bru = w_hdr.id_data.bru_cmd_vld;
   assign w_need_sys = w_hdr.id_data.sys_cmd_vld;

   assign o_exwb_tready = r_live && !invalidate && (r_state == IDLE);
   assign w_exwb_hs     = o_exwb_tready && i_exwb_tvalid;
   assign o_wbrf_tvalid = (r_state == OUT);
   assign o_wbrf_tdata  = r_wb;
   assign w_wbrf_hs     = o_wbrf_tvalid && i_wbrf_tready;

   assign w_bypass_ok = BYPASS && i_exwb_tvalid
                        && (!w_need_alu || i_alu_tvalid)
                        && (!w_need_bru || i_bru_tvalid)
                        && (!w_need_sys || i_sys_tvalid);
   assign w_unit_en   = r_live && !invalidate
                        && ((r_state == WAIT) || ((r_state == IDLE) && w_bypass_ok));
   assign w_clear     = invalidate || ((r_state == OUT) && w_wbrf_hs);

   ex_result_hold #(.T(alu_result_t)) u_hold_alu (
      .clk(clk), .rst_n(rst_n), .i_en(w_unit_en), .i_need(w_need_alu), .i_clear(w_clear),
      .i_tdata(i_alu_tdata), .i_tvalid(i_alu_tvalid), .o_tready(o_alu_tready),
      .o_done(w_done_alu), .o_data(w_alu)
   );

   ex_result_hold #(.T(bru_result_t)) u_hold_bru (
      .clk(clk), .rst_n(rst_n), .i_en(w_unit_en), .i_need(w_need_bru), .i_clear(w_clear),
      .i_tdata(i_bru_tdata), .i_tvalid(i_bru_tvalid), .o_tready(o_bru_tready),
      .o_done(w_done_bru), .o_data(w_bru)
   );

   ex_result_hold #(.T(sys_result_t)) u_hold_sys (
      .clk(clk), .rst_n(rst_n), .i_en(w_unit_en), .i_need(w_need_sys), .i_clear(w_clear),
      .i_tdata(i_sys_tdata), .i_tvalid(i_sys_tvalid), .o_tready(o_sys_tready),
      .o_done(w_done_sys), .o_data(w_sys)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load_out  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_exwb_hs) begin
               if (w_bypass_ok) begin
                  w_state_nxt = OUT;
                  w_load_out  = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (w_done_alu && w_done_bru && w_done_sys) begin
               w_state_nxt = OUT;
               w_load_out  = 1'b1;
            end
         end
         OUT: begin
            if (w_wbrf_hs) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (invalidate) begin
         w_state_nxt = IDLE;
         w_load_out  = 1'b0;
      end
   end

   // A nop needs no unit, so its wdata is forced to zero rather than stale ALU data.
   always_comb begin
      w_wb_nxt       = '0;
      w_trap         = w_need_sys && w_sys.trap;
      w_wb_nxt.rd    = w_hdr.rd;
      w_wb_nxt.pc    = w_hdr.pc;
      w_wb_nxt.wen   = w_hdr.rd_we && !w_trap && (w_hdr.rd != 5'd0);
      if (w_need_sys)      w_wb_nxt.wdata = w_sys.wdata;
      else if (w_need_bru) w_wb_nxt.wdata = w_bru.link;
      else if (w_need_alu) w_wb_nxt.wdata = w_alu.wdata;
      else                 w_wb_nxt.wdata = '0;
      w_sys_redir  = w_need_sys && (w_sys.trap || w_sys.redirect);
      w_bru_redir  = w_need_bru && w_bru.taken;
      w_redir_take = w_sys_redir || w_bru_redir;
      w_redir_pc   = w_sys_redir ? w_sys.pc : w_bru.target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_live         <= 1'b0;
         r_hdr          <= '0;
         r_wb           <= '0;
         r_take         <= 1'b0;
         r_take_pc      <= '0;
         r_redirect_vld <= 1'b0;
         r_redirect_pc  <= '0;
         r_wdog_cnt     <= '0;
         r_wdog_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         if (w_exwb_hs) r_hdr <= w_hdr_in;
         if (w_load_out) begin
            r_wb      <= w_wb_nxt;
            r_take    <= w_redir_take;
            r_take_pc <= w_redir_pc;
         end
         r_redirect_vld <= (r_state == OUT) && w_wbrf_hs && r_take && !invalidate;
         if ((r_state == OUT) && w_wbrf_hs && r_take && !invalidate) r_redirect_pc <= r_take_pc;
         if (r_state == WAIT) begin
            if (r_wdog_cnt != WDOG_LIM) r_wdog_cnt <= r_wdog_cnt + 32'd1;
         end else begin
            r_wdog_cnt <= '0;
         end
         if ((WDOG_LIM != 32'd0) && (r_wdog_cnt == WDOG_LIM)) r_wdog_err <= 1'b1;
      end
   end

   assign redirect_vld = r_redirect_vld;
   assign redirect_pc  = r_redirect_pc;
   assign wdog_err     = r_wdog_err;

endmodule

// File: doc/ex_collector.md
Name: ex_collector

Overview:
- Writeback-side counterpart of the execute dispatcher.
- Pops the per-instruction header from the dispatcher's exwb FIFO and collects the result beat from each execution unit the header names (ALU, BRU, SYS).
- Merges header and results into one writeback beat on wbrf_axis_if. The same beat feeds register-file write and EX forwarding.
- Also raises a one-cycle redirect for taken branches and traps.

Parameters:
- BYPASS, 1, when 1 a header whose required results are all valid in the same cycle goes straight to OUT, skipping WAIT.
- WDOG_CYCLES, 0, cycles allowed in WAIT before wdog_err asserts; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exwb_axis_if  axis_if.s  exwb_tdata_t  instruction header from dispatcher FIFO
- alu_axis_if  axis_if.s  alu_result_t  ALU result
- bru_axis_if  axis_if.s  bru_result_t  BRU result (taken, target, link value)
- sys_axis_if  axis_if.s  sys_result_t  System unit result (wdata, trap, redirect pc)
- wbrf_axis_if  axis_if.m  wbrf_tdata_t  merged writeback beat (rd, wen, wdata, pc)
- redirect_vld  out  1  pc redirect pulse
- redirect_pc  out  XLEN  redirect target
- invalidate  in  1  flush of in-flight instruction
- wdog_err  out  1  sticky watchdog flag

Behaviour:
- Reset: async, rst_n low. State=IDLE; wbrf tvalid=0; all tready=0; redirect_vld=0; redirect_pc=0; wdog_err=0; got_* flags cleared; hold registers zeroed.
- need_alu/need_bru/need_sys come from header id_data.{alu,bru,sys}_cmd_vld. A header needing no unit (e.g. nop) completes on header data alone.
- IDLE:
  - exwb tready=1. On exwb handshake, latch header into hdr_q and go to WAIT.
  - With BYPASS=1 and every needed unit valid that cycle, accept those unit beats too and go straight to OUT.
- WAIT:
  - Each unit's tready = need_x && !got_x. A unit beat accepted sets got_x and latches its data into hold_x.
  - Once got_x==need_x for all units, go to OUT next cycle. This adds one cycle after the last result.
  - Unit beats arriving for a unit that is not needed are not accepted: tready stays 0.
- OUT:
  - wbrf tvalid=1, with tdata registered and stable until tready.
  - wdata select priority: sys if need_sys, else bru link if need_bru, else alu.
  - wen = header rd_we && !trap && rd!=0.
  - On wbrf handshake: go to IDLE, clear got_*, pulse redirect_vld for exactly one cycle if bru taken or sys trap/redirect.
  - redirect_pc priority: sys over bru.
- Latency: IDLE→OUT minimum 1 cycle with BYPASS, 2 cycles without. Throughput: one instruction per 2 cycles, because OUT returns to IDLE.
- Backpressure: in OUT, all input treadys=0 and data is held unchanged.
- invalidate:
  - Synchronous; wins over every other event in the same cycle.
  - Drops the current instruction: state→IDLE, got_* cleared, wbrf tvalid=0 next cycle, no redirect.
  - If invalidate coincides with a wbrf handshake, the beat counts as delivered but its redirect is suppressed.
- Watchdog: counter increments each WAIT cycle and clears on leaving WAIT. wdog_err sets when counter==WDOG_CYCLES and clears only on reset.
- Reset mid-operation: all state is discarded immediately. The async assert has no handshake obligations.

Decomposition:
- offnariscv_pkg:
  - add alu_result_t, bru_result_t, sys_result_t, wbrf_tdata_t (rd, wen, wdata, pc);
  - add enum ex_col_state_e {IDLE, WAIT, OUT};
  - reuse XLEN and exwb_tdata_t.
- One sub-module: ex_result_hold. It is one unit's capture register with got flag, instantiated three times, parameterised by the tdata type.

Test Plan:
- ALU-only add: header rd=5, alu result 0x0000_00AA one cycle later, wbrf tready=1 → wbrf beat rd=5 wen=1 wdata=0xAA, 2 cycles after the header; no redirect.
- BYPASS simultaneous: header and BRU beat in the same cycle, taken=1, target=0x8000_0100, link=0x8000_0008 → wbrf next cycle with wdata=0x8000_0008; on handshake redirect_vld pulses 1 cycle, redirect_pc=0x8000_0100.
- Backpressure: wbrf tready=0 for 4 cycles in OUT → tdata constant; exwb/alu tready=0 throughout; beat delivered on the 5th cycle.
- Trap: sys beat trap=1, mtvec=0x8000_0040, header rd=3 → wen=0, redirect_pc=0x8000_0040.
- Invalidate in WAIT with ALU result pending → no wbrf beat, state IDLE. The next header (rd=7, alu 0x11) completes normally.
- Watchdog WDOG_CYCLES=8: header needs SYS, no sys beat arrives → wdog_err=1 after 8 WAIT cycles and stays set; reset (rst_n=0) clears it asynchronously.
